// File: rtl/flags_reader_pkg.sv
// Shared definitions for the matmul flag vector and its bus reader.
// Holds the sizing, FSM encoding, read word addresses and status field offsets.
// Used by the matmul, the bus decode and flags_reader so the layouts stay in step.
package flags_reader_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BUS_WIDTH  = 64;
  localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH;

  // One flag per matrix element.
  localparam int unsigned FLAG_NUM = MAX_DIM * MAX_DIM;
  localparam int unsigned IDX_W    = (FLAG_NUM > 1) ? $clog2(FLAG_NUM) : 1;
  // Wide enough to hold FLAG_NUM itself, so a fully set vector cannot wrap.
  localparam int unsigned CNT_W    = $clog2(FLAG_NUM + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Read word select.
  localparam logic RD_ADDR_FLAGS  = 1'b0;
  localparam logic RD_ADDR_STATUS = 1'b1;

  // Status word field offsets.
  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_ANY_BIT  = 1;
  localparam int unsigned STAT_CNT_LSB  = 2;
  localparam int unsigned STAT_IDX_LSB  = STAT_CNT_LSB + CNT_W;

endpackage

// File: rtl/flags_reader.sv
// Snapshots the flag vector, scans it one bit per cycle for count / lowest set index, serves two read words.
// Latency: capture to result FLAG_NUM+1 cycles; read request to ack exactly 1 cycle.
// Backpressure: none; reads never stall and may issue every cycle, capture restarts any scan in flight.
module flags_reader
  import flags_reader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 capture_i,
  input  logic [FLAG_NUM-1:0]  flags_i,
  input  logic                 clear_i,
  input  logic                 rd_req_i,
  input  logic                 rd_addr_i,
  output logic                 rd_ack_o,
  output logic [BUS_WIDTH-1:0] rd_data_o,
  output logic                 irq_o,
  output logic                 busy_o
);

  state_e               state_q, state_d;
  logic [FLAG_NUM-1:0]  snap_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     ptr_q;
  logic                 any_q;
  logic                 scanning;
  logic                 last_bit;
  logic [BUS_WIDTH-1:0] rd_word;

  assign scanning = (state_q == ST_SCAN);
  assign last_bit = (ptr_q == IDX_W'(FLAG_NUM - 1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: capture beats clear, clear beats scan progress.
  always_comb begin
    state_d = state_q;
    if (capture_i) begin
      state_d = ST_SCAN;
    end else if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_SCAN: if (last_bit) state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Snapshot and scan datapath; the first set bit seen is the lowest, so it is latched once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      any_q  <= 1'b0;
      ptr_q  <= '0;
    end else if (capture_i) begin
      snap_q <= flags_i;
      cnt_q  <= '0;
      idx_q  <= '0;
      any_q  <= 1'b0;
      ptr_q  <= '0;
    end else if (clear_i) begin
      snap_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      any_q  <= 1'b0;
      ptr_q  <= '0;
    end else if (scanning) begin
      if (snap_q[ptr_q]) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!any_q) begin
          idx_q <= ptr_q;
          any_q <= 1'b1;
        end
      end
      ptr_q <= ptr_q + IDX_W'(1);
    end
  end

  // Read mux; partial scan results are hidden until the scan completes.
  always_comb begin
    rd_word = '0;
    if (rd_addr_i == RD_ADDR_FLAGS) begin
      rd_word[FLAG_NUM-1:0] = snap_q;
    end else begin
      rd_word[STAT_BUSY_BIT] = scanning;
      if (!scanning) begin
        rd_word[STAT_ANY_BIT]              = any_q;
        rd_word[STAT_CNT_LSB +: CNT_W]     = cnt_q;
        if (any_q) rd_word[STAT_IDX_LSB +: IDX_W] = idx_q;
      end
    end
  end

  // Read response register: one ack per request, data forced to zero between acks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ack_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_ack_o  <= rd_req_i;
      rd_data_o <= rd_req_i ? rd_word : '0;
    end
  end

  assign irq_o  = (state_q == ST_DONE) && any_q;
  assign busy_o = scanning;

endmodule
